// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS_IF  = 2'd1,
    BUS_MEM = 2'd2,
    CANCEL  = 2'd3
  } arb_state_e;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic STOP        = 1'b1;
  localparam logic RST_ENABLE  = 1'b0;
  localparam logic CHIP_ENABLE = 1'b1;

endpackage

// File: rtl/mem_bus_timeout_cnt.sv
// Bus-cycle watchdog: counts waiting cycles, flags the last allowed one.
module mem_bus_timeout_cnt
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RST_ENABLE) cnt <= '0;
    else if (i_clr)            cnt <= '0;
    else if (i_en)             cnt <= cnt + 1'b1;
  end

  assign o_expire = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch / data) arbiter for a single req/ack memory bus,
// with result buffering, flush cancellation and timeout recovery.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int N_ADDR  = 32,
  parameter int N_DATA  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [5:0]        i_stall,
  input  logic              i_flush,
  input  logic              i_if_ce,
  input  logic [N_ADDR-1:0] i_if_addr,
  output logic [N_DATA-1:0] o_if_inst,
  output logic              o_if_stallreq,
  input  logic              i_mem_ce,
  input  logic              i_mem_we,
  input  logic [3:0]        i_mem_sel,
  input  logic [N_ADDR-1:0] i_mem_addr,
  input  logic [N_DATA-1:0] i_mem_wdata,
  output logic [N_DATA-1:0] o_mem_rdata,
  output logic              o_mem_stallreq,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [3:0]        o_bus_sel,
  output logic [N_ADDR-1:0] o_bus_addr,
  output logic [N_DATA-1:0] o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic [N_DATA-1:0] i_bus_rdata,
  output logic              o_bus_err
);

  arb_state_e        state;
  logic              if_valid, mem_valid;
  logic [N_DATA-1:0] if_buf, mem_buf;
  logic              busy, expire, done;

  // A side needs the bus exactly when it is stalling for it.
  assign o_if_stallreq  = (i_if_ce == CHIP_ENABLE) & ~if_valid & ~i_flush;
  assign o_mem_stallreq = (i_mem_ce == CHIP_ENABLE) & ~mem_valid & ~i_flush;
  assign o_if_inst      = if_buf;
  assign o_mem_rdata    = mem_buf;

  assign busy = (state != IDLE);
  assign done = busy & (i_bus_ack | expire);

  mem_bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (~busy | done),
    .i_en     (busy & ~i_bus_ack),
    .o_expire (expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RST_ENABLE) begin
      state       <= IDLE;
      if_valid    <= 1'b0;
      mem_valid   <= 1'b0;
      if_buf      <= '0;
      mem_buf     <= '0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_sel   <= 4'h0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_bus_err   <= 1'b0;
    end else begin
      o_bus_err <= 1'b0;

      if (i_flush) begin
        if_valid  <= 1'b0;
        mem_valid <= 1'b0;
        if_buf    <= '0;
        mem_buf   <= '0;
      end else begin
        if (if_valid && i_stall[STALL_IF] != STOP)   if_valid  <= 1'b0;
        if (mem_valid && i_stall[STALL_MEM] != STOP) mem_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (o_mem_stallreq) begin
            state       <= BUS_MEM;
            o_bus_req   <= 1'b1;
            o_bus_we    <= i_mem_we;
            o_bus_sel   <= i_mem_sel;
            o_bus_addr  <= i_mem_addr;
            o_bus_wdata <= i_mem_wdata;
          end else if (o_if_stallreq) begin
            state       <= BUS_IF;
            o_bus_req   <= 1'b1;
            o_bus_we    <= 1'b0;
            o_bus_sel   <= 4'hF;
            o_bus_addr  <= i_if_addr;
            o_bus_wdata <= '0;
          end
        end
        BUS_IF, BUS_MEM, CANCEL: begin
          if (done) begin
            state       <= IDLE;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_sel   <= 4'h0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            o_bus_err   <= ~i_bus_ack;
            // A cancelled or concurrently flushed cycle leaves no result behind.
            if (state != CANCEL && !i_flush) begin
              if (state == BUS_IF) begin
                if_buf   <= i_bus_ack ? i_bus_rdata : '0;
                if_valid <= 1'b1;
              end else begin
                mem_buf   <= i_bus_ack ? i_bus_rdata : '0;
                mem_valid <= 1'b1;
              end
            end
          end else if (i_flush) begin
            state <= CANCEL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
